// File: rtl/dm_pkg.sv
// Debug-module shared types: SBA engine states, SBCS register layout and SBA error codes.
package dm;

    localparam logic [2:0] SbErrNone    = 3'd0;
    localparam logic [2:0] SbErrTimeout = 3'd1;
    localparam logic [2:0] SbErrBadAddr = 3'd2;
    localparam logic [2:0] SbErrAlign   = 3'd3;
    localparam logic [2:0] SbErrSize    = 3'd4;
    localparam logic [2:0] SbErrOther   = 3'd7;

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitRead,
        Write,
        WaitWrite
    } sba_state_t;

    typedef struct packed {
        logic [31:29] sbversion;
        logic [28:23] zero0;
        logic         sbbusyerror;
        logic         sbbusy;
        logic         sbreadonaddr;
        logic [19:17] sbaccess;
        logic         sbautoincrement;
        logic         sbreadondata;
        logic [14:12] sberror;
        logic [11:5]  sbasize;
        logic         sbaccess128;
        logic         sbaccess64;
        logic         sbaccess32;
        logic         sbaccess16;
        logic         sbaccess8;
    } sbcs_t;

endpackage

// File: rtl/dm_sba_lane.sv
// Byte-lane steering for single-beat SBA accesses: byte enables, write-data shift, read-data align+mask.
// Purely combinational; no backpressure.
module dm_sba_lane #(
    parameter int BusWidth = 32
) (
    input  logic [$clog2(BusWidth/8)-1:0] i_off,
    input  logic [2:0]                    i_access,
    input  logic [BusWidth-1:0]           i_wdata,
    input  logic [BusWidth-1:0]           i_rdata,
    output logic [BusWidth/8-1:0]         o_be,
    output logic [BusWidth-1:0]           o_wdata,
    output logic [BusWidth-1:0]           o_rdata
);

    localparam int BeW = BusWidth / 8;

    logic [BeW-1:0]      w_be_base;
    logic [BusWidth-1:0] w_mask;

    // Low (1 << access) bytes enabled; the same pattern masks the right-aligned read data.
    always_comb begin
        w_be_base = '0;
        w_mask    = '0;
        for (int i = 0; i < BeW; i++) begin
            if (i < (1 << i_access)) begin
                w_be_base[i]     = 1'b1;
                w_mask[8*i +: 8] = 8'hFF;
            end
        end
    end

    assign o_be    = w_be_base << i_off;
    assign o_wdata = i_wdata << {i_off, 3'b000};
    assign o_rdata = (i_rdata >> {i_off, 3'b000}) & w_mask;

endmodule

// File: rtl/dm_sba_engine.sv
// System bus access engine: turns SBCS/SBADDRESS/SBDATA triggers into single-beat req/gnt/r_valid accesses.
// Trigger in N -> req in N+1; req and its fields hold until gnt, completion waits on r_valid.
module dm_sba_engine
    import dm::*;
#(
    parameter int BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic                  master_r_err_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i
);

    localparam int         OffW      = $clog2(BusWidth/8);
    localparam logic [2:0] MaxAccess = 3'(OffW);

    sba_state_t r_state, w_next;

    logic [BusWidth-1:0] r_addr;
    logic [BusWidth-1:0] r_data;
    logic [BusWidth-1:0] r_wdata;
    logic [2:0]          r_access;
    logic                r_data_vld;
    logic                r_err_vld;
    logic [2:0]          r_err;
    logic                r_abort;

    logic                w_trig_rd;
    logic                w_trig_wr;
    logic                w_trig;
    logic [BusWidth-1:0] w_trig_addr;
    logic                w_size_err;
    logic                w_align_err;
    logic                w_start;
    logic                w_pre_err;
    logic                w_done;
    logic                w_suppress;
    logic                w_ok;
    logic                w_bad;
    logic [BusWidth/8-1:0] w_be;
    logic [BusWidth-1:0] w_wdata;
    logic [BusWidth-1:0] w_rdata;

    always_comb begin
        w_trig_rd = 1'b0;
        w_trig_wr = 1'b0;
        if (sbaddress_write_valid_i && sbreadonaddr_i) begin
            w_trig_rd = 1'b1;
        end else if (sbdata_write_valid_i) begin
            w_trig_wr = 1'b1;
        end else if (sbdata_read_valid_i && sbreadondata_i) begin
            w_trig_rd = 1'b1;
        end
    end

    // A same-cycle address write is the address the access will use.
    assign w_trig_addr = sbaddress_write_valid_i ? sbaddress_i : r_addr;
    assign w_trig      = (r_state == Idle) && dmactive_i && (w_trig_rd || w_trig_wr);
    assign w_size_err  = sbaccess_i > MaxAccess;
    assign w_align_err = |(w_trig_addr & ((BusWidth'(1) << sbaccess_i) - BusWidth'(1)));
    assign w_start     = w_trig && !w_size_err && !w_align_err;
    assign w_pre_err   = w_trig && (w_size_err || w_align_err);

    assign w_done     = ((r_state == WaitRead) || (r_state == WaitWrite)) && master_r_valid_i;
    assign w_suppress = r_abort || !dmactive_i;
    assign w_ok       = w_done && !master_r_err_i && !w_suppress;
    assign w_bad      = w_done && master_r_err_i && !w_suppress;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= Idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            Idle: begin
                if (w_start) begin
                    w_next = w_trig_wr ? Write : Read;
                end
            end
            Read:      if (master_gnt_i)     w_next = WaitRead;
            Write:     if (master_gnt_i)     w_next = WaitWrite;
            WaitRead:  if (master_r_valid_i) w_next = Idle;
            WaitWrite: if (master_r_valid_i) w_next = Idle;
            default:   w_next = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_wdata    <= '0;
            r_access   <= '0;
            r_data_vld <= 1'b0;
            r_err_vld  <= 1'b0;
            r_err      <= SbErrNone;
            r_abort    <= 1'b0;
        end else begin
            r_data_vld <= w_ok && (r_state == WaitRead);
            r_err_vld  <= w_pre_err || w_bad;

            if (w_ok && (r_state == WaitRead)) begin
                r_data <= w_rdata;
            end

            if (w_pre_err) begin
                r_err <= w_size_err ? SbErrSize : SbErrAlign;
            end else if (w_bad) begin
                r_err <= SbErrBadAddr;
            end

            if (sbaddress_write_valid_i) begin
                r_addr <= sbaddress_i;
            end else if (w_ok && sbautoincrement_i) begin
                r_addr <= r_addr + (BusWidth'(1) << r_access);
            end

            if (w_start) begin
                r_access <= sbaccess_i;
                r_wdata  <= sbdata_i;
            end

            // Any dmactive drop during an access silences its completion.
            if (r_state == Idle) begin
                r_abort <= 1'b0;
            end else if (!dmactive_i) begin
                r_abort <= 1'b1;
            end
        end
    end

    dm_sba_lane #(
        .BusWidth (BusWidth)
    ) u_lane (
        .i_off    (r_addr[OffW-1:0]),
        .i_access (r_access),
        .i_wdata  (r_wdata),
        .i_rdata  (master_r_rdata_i),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata)
    );

    assign sbaddress_o     = r_addr;
    assign sbdata_o        = r_data;
    assign sbdata_valid_o  = r_data_vld;
    assign sberror_valid_o = r_err_vld;
    assign sberror_o       = r_err;
    assign sbbusy_o        = (r_state != Idle);
    assign master_req_o    = (r_state == Read) || (r_state == Write);
    assign master_we_o     = (r_state == Write);
    assign master_add_o    = r_addr;
    assign master_be_o     = master_req_o ? w_be : '0;
    assign master_wdata_o  = master_we_o ? w_wdata : '0;

endmodule

// File: tb/tb_dm_sba_engine.sv
module tb_dm_sba_engine;

    localparam int BW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          dmactive_i;
    logic [BW-1:0] sbaddress_i;
    logic          sbaddress_write_valid_i;
    logic          sbreadonaddr_i;
    logic          sbautoincrement_i;
    logic [2:0]    sbaccess_i;
    logic          sbreadondata_i;
    logic [BW-1:0] sbdata_i;
    logic          sbdata_read_valid_i;
    logic          sbdata_write_valid_i;
    logic [BW-1:0] sbaddress_o;
    logic [BW-1:0] sbdata_o;
    logic          sbdata_valid_o;
    logic          sbbusy_o;
    logic          sberror_valid_o;
    logic [2:0]    sberror_o;
    logic          master_req_o;
    logic [BW-1:0] master_add_o;
    logic          master_we_o;
    logic [BW-1:0] master_wdata_o;
    logic [BW/8-1:0] master_be_o;
    logic          master_gnt_i;
    logic          master_r_valid_i;
    logic          master_r_err_i;
    logic [BW-1:0] master_r_rdata_i;

    dm_sba_engine #(.BusWidth(BW)) dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .dmactive_i              (dmactive_i),
        .sbaddress_i             (sbaddress_i),
        .sbaddress_write_valid_i (sbaddress_write_valid_i),
        .sbreadonaddr_i          (sbreadonaddr_i),
        .sbautoincrement_i       (sbautoincrement_i),
        .sbaccess_i              (sbaccess_i),
        .sbreadondata_i          (sbreadondata_i),
        .sbdata_i                (sbdata_i),
        .sbdata_read_valid_i     (sbdata_read_valid_i),
        .sbdata_write_valid_i    (sbdata_write_valid_i),
        .sbaddress_o             (sbaddress_o),
        .sbdata_o                (sbdata_o),
        .sbdata_valid_o          (sbdata_valid_o),
        .sbbusy_o                (sbbusy_o),
        .sberror_valid_o         (sberror_valid_o),
        .sberror_o               (sberror_o),
        .master_req_o            (master_req_o),
        .master_add_o            (master_add_o),
        .master_we_o             (master_we_o),
        .master_wdata_o          (master_wdata_o),
        .master_be_o             (master_be_o),
        .master_gnt_i            (master_gnt_i),
        .master_r_valid_i        (master_r_valid_i),
        .master_r_err_i          (master_r_err_i),
        .master_r_rdata_i        (master_r_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_addr(input logic [BW-1:0] a, input logic rdon);
        sbaddress_i             = a;
        sbreadonaddr_i          = rdon;
        sbaddress_write_valid_i = 1'b1;
        tick();
        sbaddress_write_valid_i = 1'b0;
        sbreadonaddr_i          = 1'b0;
    endtask

    // Called with the engine in Read/Write; returns the cycle after r_valid.
    task automatic finish_xfer(input logic err, input logic [BW-1:0] rd);
        master_gnt_i = 1'b1;
        tick();
        master_gnt_i     = 1'b0;
        master_r_valid_i = 1'b1;
        master_r_err_i   = err;
        master_r_rdata_i = rd;
        tick();
        master_r_valid_i = 1'b0;
        master_r_err_i   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int vld_cnt;
        logic stable;

        rst_ni = 1'b0;
        dmactive_i = 1'b1;
        sbaddress_i = '0; sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
        sbautoincrement_i = 1'b0; sbaccess_i = 3'd2; sbreadondata_i = 1'b0;
        sbdata_i = '0; sbdata_read_valid_i = 1'b0; sbdata_write_valid_i = 1'b0;
        master_gnt_i = 1'b0; master_r_valid_i = 1'b0; master_r_err_i = 1'b0;
        master_r_rdata_i = '0;
        #12;
        check("rst_busy", sbbusy_o, 0);
        check("rst_req", master_req_o, 0);
        check("rst_addr", sbaddress_o, 0);
        check("rst_data", sbdata_o, 0);
        check("rst_pulses", {sbdata_valid_o, sberror_valid_o, sberror_o}, 0);
        check("rst_bus", {master_we_o, master_be_o, master_wdata_o}, 0);
        rst_ni = 1'b1;
        tick();

        // 1: word read at 0x1000; busy spans Read (1 cycle) + WaitRead (1 cycle)
        busy_cnt = 0; vld_cnt = 0;
        wr_addr(32'h1000, 1'b1);
        check("t1_req", master_req_o, 1);
        check("t1_be", master_be_o, 4'hF);
        check("t1_add", master_add_o, 32'h1000);
        check("t1_we", master_we_o, 0);
        busy_cnt += int'(sbbusy_o);
        master_gnt_i = 1'b1;
        tick();
        master_gnt_i = 1'b0;
        check("t1_req_after_gnt", master_req_o, 0);
        busy_cnt += int'(sbbusy_o);
        master_r_valid_i = 1'b1; master_r_rdata_i = 32'hDEADBEEF;
        tick();
        master_r_valid_i = 1'b0;
        vld_cnt += int'(sbdata_valid_o);
        busy_cnt += int'(sbbusy_o);
        check("t1_data", sbdata_o, 32'hDEADBEEF);
        tick();
        vld_cnt += int'(sbdata_valid_o);
        busy_cnt += int'(sbbusy_o);
        check("t1_busy_cycles", busy_cnt, 2);
        check("t1_valid_pulses", vld_cnt, 1);

        // 2: halfword write at 0x1002 with autoincrement
        wr_addr(32'h1002, 1'b0);
        sbaccess_i = 3'd1; sbautoincrement_i = 1'b1;
        sbdata_i = 32'h0000ABCD; sbdata_write_valid_i = 1'b1;
        tick();
        sbdata_write_valid_i = 1'b0;
        check("t2_req_we", {master_req_o, master_we_o}, 2'b11);
        check("t2_be", master_be_o, 4'hC);
        check("t2_wdata", master_wdata_o, 32'hABCD0000);
        finish_xfer(1'b0, 32'h0);
        check("t2_no_pulse", {sbdata_valid_o, sberror_valid_o}, 0);
        check("t2_incr", sbaddress_o, 32'h1004);
        check("t2_idle", sbbusy_o, 0);

        // 3: pre-check errors
        sbaccess_i = 3'd2; sbautoincrement_i = 1'b0;
        wr_addr(32'h1001, 1'b1);
        check("t3_align_err", {sberror_valid_o, sberror_o}, {1'b1, 3'd3});
        check("t3_align_noreq", {master_req_o, sbbusy_o}, 0);
        tick();
        check("t3_align_pulse_end", {sberror_valid_o, master_req_o}, 0);
        sbaccess_i = 3'd3;
        wr_addr(32'h1000, 1'b1);
        check("t3_size_err", {sberror_valid_o, sberror_o}, {1'b1, 3'd4});
        check("t3_size_noreq", master_req_o, 0);
        sbaccess_i = 3'd2;
        tick();

        // 4: bus error keeps data and address; word autoincrement wraps
        sbautoincrement_i = 1'b1;
        wr_addr(32'h2000, 1'b1);
        finish_xfer(1'b1, 32'h12345678);
        check("t4_err", {sberror_valid_o, sberror_o}, {1'b1, 3'd2});
        check("t4_no_valid", sbdata_valid_o, 0);
        check("t4_data_kept", sbdata_o, 32'hDEADBEEF);
        check("t4_addr_kept", sbaddress_o, 32'h2000);
        wr_addr(32'hFFFFFFFC, 1'b1);
        finish_xfer(1'b0, 32'h55AA55AA);
        check("t4_wrap", sbaddress_o, 32'h0);
        check("t4_wrap_data", {sbdata_valid_o, sbdata_o}, {1'b1, 32'h55AA55AA});

        // halfword read at offset 2: upper half right-aligned and masked
        sbautoincrement_i = 1'b0; sbaccess_i = 3'd1;
        wr_addr(32'h1002, 1'b1);
        check("t4_half_be", master_be_o, 4'hC);
        finish_xfer(1'b0, 32'hBEEF1234);
        check("t4_half_data", sbdata_o, 32'h0000BEEF);
        sbaccess_i = 3'd2;

        // 5: grant withheld for 5 cycles
        wr_addr(32'h3000, 1'b1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(master_req_o === 1'b1 && master_add_o === 32'h3000 && master_be_o === 4'hF))
                stable = 1'b0;
            tick();
        end
        check("t5_stable", stable, 1);
        check("t5_still_req", master_req_o, 1);
        finish_xfer(1'b0, 32'h0BADF00D);
        check("t5_data", sbdata_o, 32'h0BADF00D);

        // dmactive drops during WaitRead
        sbautoincrement_i = 1'b1;
        wr_addr(32'h3004, 1'b1);
        master_gnt_i = 1'b1;
        tick();
        master_gnt_i = 1'b0;
        dmactive_i = 1'b0;
        tick();
        check("t5_waiting", sbbusy_o, 1);
        master_r_valid_i = 1'b1; master_r_rdata_i = 32'h99999999;
        tick();
        master_r_valid_i = 1'b0;
        check("t5_no_pulses", {sbdata_valid_o, sberror_valid_o}, 0);
        check("t5_idle", sbbusy_o, 0);
        check("t5_data_kept", sbdata_o, 32'h0BADF00D);
        check("t5_no_incr", sbaddress_o, 32'h3004);
        wr_addr(32'h4000, 1'b1);
        check("t5_inactive_ignored", {sbbusy_o, sberror_valid_o}, 0);
        check("t5_inactive_addr", sbaddress_o, 32'h4000);
        dmactive_i = 1'b1;
        sbautoincrement_i = 1'b0;

        // 6: write beats readondata in the same cycle; triggers while busy are dropped
        sbreadondata_i = 1'b1;
        sbdata_i = 32'h11223344;
        sbdata_write_valid_i = 1'b1; sbdata_read_valid_i = 1'b1;
        tick();
        sbdata_write_valid_i = 1'b0; sbdata_read_valid_i = 1'b0;
        check("t6_write_taken", {master_req_o, master_we_o}, 2'b11);
        check("t6_wdata", master_wdata_o, 32'h11223344);
        sbdata_read_valid_i = 1'b1;
        tick();
        sbdata_read_valid_i = 1'b0;
        check("t6_busy_ignored", {master_req_o, master_we_o}, 2'b11);
        finish_xfer(1'b0, 32'h0);
        tick();
        check("t6_no_followup", {sbbusy_o, master_req_o}, 0);
        sbreadondata_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
